// File: rtl/conv_kxk_mc_systolic_pkg.sv
// conv_pkg: shared helpers for the systolic convolution family.
//   clog2       - ceiling log2 usable in constant expressions
//   acc_w_ok    - accumulator width legality test used at elaboration
//   sat_hi/lo   - signed saturation bounds for an OUT_W-bit result
//   col_lsb     - bit offset of channel c, row r inside a packed column
//   wgt_lsb     - bit offset of w[c][r][k] inside the packed weight bus
package conv_pkg;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((32'sd1 <<< r) < v) begin
         r = r + 1;
      end
      return r;
   endfunction

   function automatic bit acc_w_ok(input int acc_w, input int data_w, input int coef_w,
                                   input int k, input int cin);
      return (acc_w >= (data_w + coef_w + clog2(k * k * cin) + 1));
   endfunction

   function automatic longint sat_hi(input int out_w);
      return (64'sd1 <<< (out_w - 1)) - 64'sd1;
   endfunction

   function automatic longint sat_lo(input int out_w);
      return -(64'sd1 <<< (out_w - 1));
   endfunction

   function automatic int col_lsb(input int c, input int r, input int k, input int data_w);
      return (c * k + r) * data_w;
   endfunction

   function automatic int wgt_lsb(input int c, input int r, input int kk, input int k,
                                  input int coef_w);
      return ((c * k + r) * k + kk) * coef_w;
   endfunction

endpackage

// File: rtl/conv_kxk_mc_systolic_requant.sv
// conv_requant: optional ReLU, round-half-up arithmetic right shift and
// signed saturation, followed by one register stage advanced by en.
//   clk, rst     - clock, synchronous active-high reset
//   en           - stage advance enable (pipeline not frozen)
//   in_valid     - acc carries a real sum this cycle
//   acc          - signed sum+bias
//   shift        - right-shift amount, relu_en - clamp negatives to 0
//   out_valid    - registered valid
//   pixel        - registered saturated result
//   acc_q        - registered copy of acc, aligned with pixel
module conv_requant
   import conv_pkg::*;
#(
   parameter int ACC_W   = 32,
   parameter int OUT_W   = 8,
   parameter int SHIFT_W = 5
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    in_valid,
   input  logic signed [ACC_W-1:0] acc,
   input  logic [SHIFT_W-1:0]      shift,
   input  logic                    relu_en,
   output logic                    out_valid,
   output logic signed [OUT_W-1:0] pixel,
   output logic signed [ACC_W-1:0] acc_q
);
   // One spare bit so adding the rounding constant cannot wrap.
   localparam int EXT_W = ACC_W + 1;
   localparam logic signed [EXT_W-1:0] SAT_HI     = EXT_W'(sat_hi(OUT_W));
   localparam logic signed [EXT_W-1:0] SAT_LO     = EXT_W'(sat_lo(OUT_W));
   localparam logic signed [OUT_W-1:0] SAT_HI_OUT = OUT_W'(sat_hi(OUT_W));
   localparam logic signed [OUT_W-1:0] SAT_LO_OUT = OUT_W'(sat_lo(OUT_W));
   localparam logic signed [EXT_W-1:0] ONE_EXT    = {{(EXT_W-1){1'b0}}, 1'b1};
   localparam logic [SHIFT_W-1:0]      SHIFT_ONE  = {{(SHIFT_W-1){1'b0}}, 1'b1};

   logic signed [EXT_W-1:0] relu_s;
   logic signed [EXT_W-1:0] rnd_s;
   logic signed [EXT_W-1:0] shifted_s;
   logic signed [OUT_W-1:0] sat_s;

   // ReLU, rounding shift and saturation of the incoming sum.
   always_comb begin
      relu_s    = {EXT_W{1'b0}};
      rnd_s     = {EXT_W{1'b0}};
      shifted_s = {EXT_W{1'b0}};
      sat_s     = {OUT_W{1'b0}};
      if (relu_en && acc[ACC_W-1]) begin
         relu_s = {EXT_W{1'b0}};
      end else begin
         relu_s = EXT_W'(acc);
      end
      if (shift != {SHIFT_W{1'b0}}) begin
         rnd_s     = relu_s + (ONE_EXT <<< (shift - SHIFT_ONE));
         shifted_s = rnd_s >>> shift;
      end else begin
         rnd_s     = relu_s;
         shifted_s = relu_s;
      end
      if (shifted_s > SAT_HI) begin
         sat_s = SAT_HI_OUT;
      end else if (shifted_s < SAT_LO) begin
         sat_s = SAT_LO_OUT;
      end else begin
         sat_s = shifted_s[OUT_W-1:0];
      end
   end

   // Output register; data only changes on a valid beat so bubbles keep it stable.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         pixel     <= {OUT_W{1'b0}};
         acc_q     <= {ACC_W{1'b0}};
      end else if (en) begin
         out_valid <= in_valid;
         if (in_valid) begin
            pixel <= sat_s;
            acc_q <= acc;
         end
      end
   end

endmodule

// File: rtl/conv_kxk_mc_systolic.sv
// conv_kxk_mc_systolic: KxK signed convolution summed over CIN channels
// from a column-serial stream, plus bias, ReLU, requantisation.
//   clk, rst            - clock, synchronous active-high reset
//   in_valid/in_ready   - input column handshake, in_sol marks row start
//   in_col              - CIN*K pixels of one column
//   weights, bias       - quasi-static coefficients (k=0 is oldest column)
//   shift, relu_en      - requantisation controls
//   out_valid/out_ready - output handshake
//   out_pixel, out_acc  - saturated result and the raw sum+bias behind it
// Pipeline: E0 window, E1 products, E2 channel sums, E3 total+bias,
// E4 requantised output. A stalled output freezes every stage.
module conv_kxk_mc_systolic
   import conv_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int COEF_W  = 8,
   parameter int K       = 3,
   parameter int CIN     = 4,
   parameter int ACC_W   = 32,
   parameter int OUT_W   = 8,
   parameter int SHIFT_W = 5
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       in_sol,
   input  logic [CIN*K*DATA_W-1:0]    in_col,
   input  logic [CIN*K*K*COEF_W-1:0]  weights,
   input  logic [ACC_W-1:0]           bias,
   input  logic [SHIFT_W-1:0]         shift,
   input  logic                       relu_en,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic signed [OUT_W-1:0]    out_pixel,
   output logic signed [ACC_W-1:0]    out_acc
);
   localparam int COL_W  = CIN * K * DATA_W;
   localparam int PROD_W = DATA_W + COEF_W;
   localparam int NPROD  = CIN * K * K;
   localparam int CNT_W  = clog2(K + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(K);
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   if (!acc_w_ok(ACC_W, DATA_W, COEF_W, K, CIN)) begin : g_bad_acc_w
      $error("conv_kxk_mc_systolic: ACC_W too narrow for DATA_W/COEF_W/K/CIN");
   end
   if (K < 2) begin : g_bad_k
      $error("conv_kxk_mc_systolic: K must be at least 2");
   end

   logic                     en_s;
   logic                     accept_s;
   logic                     fire_s;
   logic [CNT_W-1:0]         col_cnt_r;
   logic [CNT_W-1:0]         col_cnt_nxt_s;
   logic [COL_W-1:0]         win_r [K];
   logic                     v0_r, v1_r, v2_r, v3_r;
   logic signed [PROD_W-1:0] prod_s [NPROD];
   logic signed [PROD_W-1:0] prod_r [NPROD];
   logic signed [ACC_W-1:0]  ch_sum_s [CIN];
   logic signed [ACC_W-1:0]  ch_sum_r [CIN];
   logic signed [ACC_W-1:0]  acc_s;
   logic signed [ACC_W-1:0]  acc_r;

   assign en_s     = !out_valid || out_ready;
   assign in_ready = en_s;
   assign accept_s = in_valid && en_s;
   // A window is complete once K columns have arrived since the last row start.
   assign fire_s   = accept_s && (col_cnt_nxt_s == CNT_FULL);

   // Column count after this beat: restart on in_sol, otherwise saturate at K.
   always_comb begin
      col_cnt_nxt_s = col_cnt_r;
      if (in_sol) begin
         col_cnt_nxt_s = CNT_ONE;
      end else if (col_cnt_r == CNT_FULL) begin
         col_cnt_nxt_s = CNT_FULL;
      end else begin
         col_cnt_nxt_s = col_cnt_r + CNT_ONE;
      end
   end

   // E0: column shift register (newest at K-1) and row column counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         col_cnt_r <= {CNT_W{1'b0}};
         v0_r      <= 1'b0;
         for (int k = 0; k < K; k++) begin
            win_r[k] <= {COL_W{1'b0}};
         end
      end else if (en_s) begin
         v0_r <= fire_s;
         if (accept_s) begin
            col_cnt_r <= col_cnt_nxt_s;
            for (int k = 0; k < K - 1; k++) begin
               win_r[k] <= win_r[k+1];
            end
            win_r[K-1] <= in_col;
         end
      end
   end

   // Signed pixel-by-weight products for every channel, row and column.
   always_comb begin
      for (int c = 0; c < CIN; c++) begin
         for (int r = 0; r < K; r++) begin
            for (int kk = 0; kk < K; kk++) begin
               prod_s[(c*K+r)*K+kk] =
                  $signed(win_r[kk][col_lsb(c, r, K, DATA_W) +: DATA_W]) *
                  $signed(weights[wgt_lsb(c, r, kk, K, COEF_W) +: COEF_W]);
            end
         end
      end
   end

   // Per-channel reduction of the registered products, sign-extended to ACC_W.
   always_comb begin
      for (int c = 0; c < CIN; c++) begin
         ch_sum_s[c] = {ACC_W{1'b0}};
         for (int j = 0; j < K * K; j++) begin
            ch_sum_s[c] = ch_sum_s[c] + ACC_W'(prod_r[c*K*K+j]);
         end
      end
   end

   // Cross-channel reduction plus bias.
   always_comb begin
      acc_s = $signed(bias);
      for (int c = 0; c < CIN; c++) begin
         acc_s = acc_s + ch_sum_r[c];
      end
   end

   // E1..E3 pipeline registers with their valid bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_r  <= 1'b0;
         v2_r  <= 1'b0;
         v3_r  <= 1'b0;
         acc_r <= {ACC_W{1'b0}};
         for (int i = 0; i < NPROD; i++) begin
            prod_r[i] <= {PROD_W{1'b0}};
         end
         for (int c = 0; c < CIN; c++) begin
            ch_sum_r[c] <= {ACC_W{1'b0}};
         end
      end else if (en_s) begin
         v1_r     <= v0_r;
         v2_r     <= v1_r;
         v3_r     <= v2_r;
         prod_r   <= prod_s;
         ch_sum_r <= ch_sum_s;
         acc_r    <= acc_s;
      end
   end

   // E4: requantisation and the output register.
   conv_requant #(
      .ACC_W   (ACC_W),
      .OUT_W   (OUT_W),
      .SHIFT_W (SHIFT_W)
   ) u_requant (
      .clk       (clk),
      .rst       (rst),
      .en        (en_s),
      .in_valid  (v3_r),
      .acc       (acc_r),
      .shift     (shift),
      .relu_en   (relu_en),
      .out_valid (out_valid),
      .pixel     (out_pixel),
      .acc_q     (out_acc)
   );

endmodule

// File: tb/tb_conv_kxk_mc_systolic.sv
// Scoreboard bench: the driver updates a row-history model on every accepted
// column and queues the expected (sum+bias, pixel); a negedge monitor pops
// and compares whenever an output is transferred.
module tb_conv_kxk_mc_systolic;
   localparam int DATA_W = 8, COEF_W = 8, K = 3, CIN = 4;
   localparam int ACC_W = 32, OUT_W = 8, SHIFT_W = 5;
   localparam int COL_W = CIN * K * DATA_W;
   localparam int WGT_W = CIN * K * K * COEF_W;

   logic clk = 1'b0, rst = 1'b1;
   logic in_valid = 1'b0, in_sol = 1'b0, relu_en = 1'b0, out_ready = 1'b1;
   logic in_ready, out_valid;
   logic [COL_W-1:0] in_col = '0;
   logic [WGT_W-1:0] weights = '0;
   logic [ACC_W-1:0] bias = '0;
   logic [SHIFT_W-1:0] shift = '0;
   logic signed [OUT_W-1:0] out_pixel;
   logic signed [ACC_W-1:0] out_acc;

   conv_kxk_mc_systolic #(.DATA_W(DATA_W), .COEF_W(COEF_W), .K(K), .CIN(CIN),
                          .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sol(in_sol),
      .in_col(in_col), .weights(weights), .bias(bias), .shift(shift), .relu_en(relu_en),
      .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel), .out_acc(out_acc));

   always #5 clk = ~clk;

   typedef struct { longint acc; longint pix; } exp_t;
   exp_t exp_q[$];
   logic [COL_W-1:0] hist[$];
   int checks = 0, errors = 0;
   bit stall = 1'b0, rand_ready = 1'b0;

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   function automatic longint pix_of(input logic [COL_W-1:0] col, input int c, input int r);
      logic signed [DATA_W-1:0] p;
      p = col[(c*K+r)*DATA_W +: DATA_W];
      return longint'(p);
   endfunction

   function automatic longint wgt_of(input int c, input int r, input int k);
      logic signed [COEF_W-1:0] w;
      w = weights[((c*K+r)*K+k)*COEF_W +: COEF_W];
      return longint'(w);
   endfunction

   // Plain-arithmetic requantisation: ReLU, round half up, floor shift, clamp.
   function automatic longint ref_pix(input longint acc, input int sh, input bit relu);
      longint v, hi, lo;
      hi = (longint'(1) << (OUT_W - 1)) - 1;
      lo = -(longint'(1) << (OUT_W - 1));
      v = (relu && acc < 0) ? 0 : acc;
      if (sh > 0) v = (v + (longint'(1) << (sh - 1))) >>> sh;
      if (v > hi) v = hi;
      if (v < lo) v = lo;
      return v;
   endfunction

   // Row model: the last K columns since in_sol form the window (hist[0] oldest).
   task automatic model_accept(input bit sol, input logic [COL_W-1:0] col);
      exp_t e;
      longint acc;
      if (sol) hist.delete();
      hist.push_back(col);
      if (hist.size() > K) void'(hist.pop_front());
      if (hist.size() == K) begin
         acc = longint'($signed(bias));
         for (int c = 0; c < CIN; c++)
            for (int r = 0; r < K; r++)
               for (int k = 0; k < K; k++)
                  acc += pix_of(hist[k], c, r) * wgt_of(c, r, k);
         e.acc = acc;
         e.pix = ref_pix(acc, int'(shift), relu_en);
         exp_q.push_back(e);
      end
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input bit sol, input logic [COL_W-1:0] col);
      int n;
      n = 0;
      in_valid = 1'b1; in_sol = sol; in_col = col;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) begin
         checks++; errors++;
         $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
         in_valid = 1'b0; in_sol = 1'b0;
      end else begin
         model_accept(sol, col);
         @(posedge clk); #1;
         in_valid = 1'b0; in_sol = 1'b0;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < 500) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("drain_pending", exp_q.size(), 0);
      exp_q.delete();
      repeat (4) @(posedge clk);
      #1;
   endtask

   function automatic logic [COL_W-1:0] const_col(input int v);
      logic [COL_W-1:0] col;
      for (int i = 0; i < CIN * K; i++) col[i*DATA_W +: DATA_W] = DATA_W'(v);
      return col;
   endfunction

   function automatic logic [COL_W-1:0] rand_col();
      logic [COL_W-1:0] col;
      for (int i = 0; i < CIN * K; i++) col[i*DATA_W +: DATA_W] = DATA_W'($urandom);
      return col;
   endfunction

   function automatic logic [COL_W-1:0] ramp_col(input int j);
      logic [COL_W-1:0] col;
      for (int c = 0; c < CIN; c++)
         for (int r = 0; r < K; r++)
            col[(c*K+r)*DATA_W +: DATA_W] = DATA_W'(j * 5 + c * 3 + r - 12);
      return col;
   endfunction

   task automatic set_weights_const(input int v);
      for (int i = 0; i < CIN * K * K; i++) weights[i*COEF_W +: COEF_W] = COEF_W'(v);
   endtask

   task automatic set_weights_rand();
      for (int i = 0; i < CIN * K * K; i++) weights[i*COEF_W +: COEF_W] = COEF_W'($urandom);
   endtask

   task automatic send_row(input int ncols, input int v);
      for (int j = 0; j < ncols; j++) send(j == 0, const_col(v));
   endtask

   // Output sink: ready is forced low during a stall, random or always high otherwise.
   initial begin
      forever begin
         @(posedge clk); #1;
         out_ready = stall ? 1'b0 : (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
      end
   end

   // Monitor: stall behaviour, hold stability and scoreboard comparison.
   logic held = 1'b0;
   logic signed [OUT_W-1:0] held_pix;
   logic signed [ACC_W-1:0] held_acc;
   exp_t got_e;
   always @(negedge clk) begin
      if (rst) begin
         held = 1'b0;
      end else begin
         if (held) begin
            check("hold_valid", out_valid, 1);
            check("hold_pixel", out_pixel, held_pix);
            check("hold_acc", out_acc, held_acc);
         end
         if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
         held = out_valid && !out_ready;
         held_pix = out_pixel;
         held_acc = out_acc;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_output", 1, 0);
            end else begin
               got_e = exp_q.pop_front();
               check("out_acc", longint'(out_acc), got_e.acc);
               check("out_pixel", longint'(out_pixel), got_e.pix);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1; rst = 1'b0;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_pixel", out_pixel, 0);
      check("rst_out_acc", out_acc, 0);
      check("rst_in_ready", in_ready, 1);

      // Unity row of 5 columns, with first-output latency
      set_weights_const(1); bias = '0; shift = '0; relu_en = 1'b0;
      send(1'b1, const_col(1)); send(1'b0, const_col(1)); send(1'b0, const_col(1));
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk); #1;
         check("latency_out_valid", out_valid, (i == 4) ? 1 : 0);
      end
      send(1'b0, const_col(1)); send(1'b0, const_col(1));
      drain();

      // Saturation both ways, with and without ReLU
      set_weights_const(127);  send_row(3, 127); drain();
      set_weights_const(-128); send_row(3, 127); drain();
      relu_en = 1'b1;          send_row(3, 127); drain();

      // Rounding and negative bias
      relu_en = 1'b0; set_weights_const(1); shift = 5'd3;
      send_row(3, 1); drain();
      bias = -32'sd100; send_row(3, 1); drain();

      // Backpressure: three-cycle stall in the middle of an 8-column ramp
      set_weights_rand(); bias = 32'sd37; shift = 5'd4;
      fork
         for (int j = 0; j < 8; j++) send(j == 0, ramp_col(j));
         begin
            repeat (6) @(posedge clk);
            stall = 1'b1;
            repeat (3) @(posedge clk);
            stall = 1'b0;
         end
      join
      drain();

      // Mid-row in_sol discards the first two columns
      shift = 5'd2;
      send(1'b1, rand_col()); send(1'b0, rand_col());
      send(1'b1, rand_col()); send(1'b0, rand_col()); send(1'b0, rand_col());
      drain();

      // Reset mid-stream drops in-flight windows
      for (int j = 0; j < 5; j++) send(j == 0, rand_col());
      rst = 1'b1;
      exp_q.delete(); hist.delete();
      repeat (2) @(posedge clk);
      #1; rst = 1'b0;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_out_pixel", out_pixel, 0);
      check("mid_rst_out_acc", out_acc, 0);
      check("mid_rst_in_ready", in_ready, 1);
      send(1'b1, rand_col()); send(1'b0, rand_col());
      repeat (8) @(posedge clk); #1;
      send(1'b0, rand_col());
      drain();

      // Randomised rows, random configuration and random downstream ready
      for (int round = 0; round < 8; round++) begin
         set_weights_rand();
         bias = ACC_W'(int'($urandom_range(0, 2000000)) - 1000000);
         shift = SHIFT_W'($urandom_range(0, 12));
         relu_en = $urandom_range(0, 1);
         rand_ready = 1'b1;
         for (int j = 0; j < 24; j++) begin
            send((j == 0) || ($urandom_range(0, 5) == 0), rand_col());
            if ($urandom_range(0, 4) == 0) begin
               @(posedge clk); #1;
            end
         end
         drain();
         rand_ready = 1'b0;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
